// File: rtl/neureka_package.sv
// +-----------------------------------------------------------------------------+
// | neureka_package                                                             |
// | Shared constants and types for the NEUREKA TCDM port synchronizer.          |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

package neureka_package;

  localparam int unsigned NEUREKA_PORT_SYNC_DEPTH = 2;
  localparam int unsigned TCDM_DW                 = 32;
  localparam int unsigned TCDM_AW                 = 32;

  typedef struct packed {
    logic [TCDM_DW-1:0] data;
  } tcdm_port_resp_t;

endpackage

`default_nettype wire

// File: rtl/neureka_port_sync_fifo.sv
// +-----------------------------------------------------------------------------+
// | neureka_port_sync_fifo                                                      |
// | Per-port response FIFO with empty-bypass; push and pop may coincide.        |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module neureka_port_sync_fifo
  import neureka_package::*;
#(
  parameter int unsigned DEPTH = NEUREKA_PORT_SYNC_DEPTH
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  tcdm_port_resp_t data_i,
  input  logic            pop_i,
  output logic            valid_o,
  output tcdm_port_resp_t data_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  tcdm_port_resp_t mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            empty, full, do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign valid_o = ~empty | push_i;
  assign data_o  = empty ? data_i : mem_q[rptr_q];

  // A push popped in the same cycle while empty bypasses storage entirely.
  assign do_push = push_i & ~(pop_i & empty);
  assign do_pop  = pop_i & ~empty;

  assign wptr_d = do_push ? ptr_inc(wptr_q) : wptr_q;
  assign rptr_d = do_pop  ? ptr_inc(rptr_q) : rptr_q;
  assign cnt_d  = cnt_q + CW'(do_push) - CW'(do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(push_i && full && !pop_i))
        else $error("neureka_port_sync_fifo: push into full FIFO without pop");
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/neureka_tcdm_port_sync.sv
// +-----------------------------------------------------------------------------+
// | neureka_tcdm_port_sync                                                      |
// | Splits one wide TCDM access into MP narrow ports and re-joins responses.    |
// | Optional stall counter: NEUREKA_TCDM_PORT_SYNC_PERF_EN.                     |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module neureka_tcdm_port_sync
  import neureka_package::*;
#(
  parameter int unsigned MP    = 9,
  parameter int unsigned DEPTH = NEUREKA_PORT_SYNC_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [31:0]           add_i,
  input  logic                  wen_i,
  input  logic [MP*4-1:0]       be_i,
  input  logic [MP*32-1:0]      data_i,
  output logic                  r_valid_o,
  output logic [MP*32-1:0]      r_data_o,
  output logic [MP-1:0]         tcdm_req_o,
  input  logic [MP-1:0]         tcdm_gnt_i,
  output logic [MP-1:0][31:0]   tcdm_add_o,
  output logic [MP-1:0]         tcdm_wen_o,
  output logic [MP-1:0][3:0]    tcdm_be_o,
  output logic [MP-1:0][31:0]   tcdm_data_o,
  input  logic [MP-1:0][31:0]   tcdm_r_data_i,
  input  logic [MP-1:0]         tcdm_r_valid_i,
  output logic [31:0]           perf_stall_cnt_o
);

  localparam int unsigned OW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH + 2);

  logic [MP-1:0]   granted_q, granted_d;
  logic [OW-1:0]   outstanding_q, outstanding_d;
  logic            credit_ok, all_valid, rd_gnt, issue;
  logic [MP-1:0]   fifo_valid;
  tcdm_port_resp_t fifo_head [MP];

  assign all_valid = &fifo_valid;
  assign r_valid_o = all_valid & ~rst_i;

  // A read may also issue while a wide response is being popped: the narrow
  // responses of the new request cannot land before that slot is freed.
  assign credit_ok = wen_i ? ((outstanding_q < OW'(DEPTH)) | all_valid) : 1'b1;
  assign issue     = req_i & credit_ok & ~rst_i;

  assign tcdm_req_o = {MP{issue}} & ~granted_q;
  assign gnt_o      = issue & (&(granted_q | tcdm_gnt_i));
  assign rd_gnt     = gnt_o & wen_i;

  assign granted_d = gnt_o ? '0 : (granted_q | (tcdm_gnt_i & tcdm_req_o));

  always_comb begin
    outstanding_d = outstanding_q;
    case ({rd_gnt, r_valid_o})
      2'b10:   outstanding_d = outstanding_q + OW'(1);
      2'b01:   outstanding_d = outstanding_q - OW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      granted_q     <= '0;
      outstanding_q <= '0;
    end else begin
      granted_q     <= granted_d;
      outstanding_q <= outstanding_d;
    end
  end

  for (genvar ii = 0; ii < MP; ii++) begin : g_port
    logic [PW-1:0]   rd_pend_q, rd_pend_d;
    logic            push, rd_issue;
    tcdm_port_resp_t push_data;

    assign tcdm_add_o[ii]  = add_i + 32'(4 * ii);
    assign tcdm_wen_o[ii]  = wen_i;
    assign tcdm_be_o[ii]   = be_i[4*ii +: 4];
    assign tcdm_data_o[ii] = data_i[32*ii +: 32];

    // Only responses owed to granted reads enter the FIFO; write acks are dropped.
    assign rd_issue       = tcdm_req_o[ii] & tcdm_gnt_i[ii] & wen_i;
    assign push           = tcdm_r_valid_i[ii] & (rd_pend_q != '0);
    assign push_data.data = tcdm_r_data_i[ii];
    assign rd_pend_d      = rd_pend_q + PW'(rd_issue) - PW'(push);

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) rd_pend_q <= '0;
      else       rd_pend_q <= rd_pend_d;
    end

    neureka_port_sync_fifo #(
      .DEPTH (DEPTH)
    ) i_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .data_i  (push_data),
      .pop_i   (r_valid_o),
      .valid_o (fifo_valid[ii]),
      .data_o  (fifo_head[ii])
    );

    assign r_data_o[32*ii +: 32] = fifo_head[ii].data;
  end

`ifdef NEUREKA_TCDM_PORT_SYNC_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign stall_cnt_d = (req_i & ~gnt_o & ~(&stall_cnt_q)) ? stall_cnt_q + 32'd1 : stall_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign perf_stall_cnt_o = stall_cnt_q;
`else
  assign perf_stall_cnt_o = '0;
`endif

endmodule

`default_nettype wire
